bird_ctrl: RTL and testbench
============================

BIRD_CTRL -- requirements
Module: bird_ctrl

Interface
REQ-001 The block SHALL have parameter FALL_PERIOD, default 16: clock cycles between gravity steps, minimum 2.
REQ-002 The block SHALL have parameter N_ROWS, default 8: light rows in the bird column.
REQ-003 The block SHALL have parameter START_ROW, default 4: bird row on reset and restart.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 The block SHALL have port key, input, 1 bit: player button level, already synchronised.
REQ-007 The block SHALL have port pipe_col, input, N_ROWS bits: pipe occupancy of the bird's column.
REQ-008 The block SHALL have port pipe_pass, input, 1 bit: one-cycle pulse when a pipe clears the bird.
REQ-009 The block SHALL have port bird_leds, output, N_ROWS bits: one-hot bird position; bit 0 is ground.
REQ-010 The block SHALL have port flap, output, 1 bit: registered one-cycle up pulse for the light cells.
REQ-011 The block SHALL have port fall, output, 1 bit: registered one-cycle down pulse for the light cells.
REQ-012 The block SHALL have port game_over, output, 1 bit: high in DEAD.
REQ-013 The block SHALL have port score, output, 7 bits: pipes passed, binary.

Function
REQ-014 The block SHALL form press = key & ~key_q, where key_q is key delayed one cycle; key held high does not repeat.
REQ-015 The block SHALL implement FSM states IDLE, PLAY and DEAD.
REQ-016 In IDLE the block SHALL hold row = START_ROW, keep the gravity counter at 0, and move to PLAY on press; that press also flaps.
REQ-017 In PLAY the gravity counter SHALL increment every cycle and wrap to 0 when it reaches FALL_PERIOD-1 (a gravity step).
REQ-018 On a PLAY press the block SHALL set row to min(row+1, N_ROWS-1), pulse flap next cycle, and clear the counter; flap pulses even at the top row.
REQ-019 On a gravity step without press the block SHALL pulse fall next cycle and set row to row-1.
REQ-020 A gravity step at row 0 SHALL instead move to DEAD with row held at 0; fall still pulses.
REQ-021 When press and a gravity step coincide, press SHALL win; there is no fall pulse.
REQ-022 In PLAY, a nonzero (bird_leds & pipe_col) SHALL move to DEAD next cycle, with priority over press and gravity.
REQ-023 On collision there SHALL be no row change and no flap or fall pulse.
REQ-024 In PLAY, pipe_pass SHALL increment score, saturating at 99; pipe_pass is ignored in IDLE and DEAD.
REQ-025 In DEAD the block SHALL freeze row and score and assert game_over.
REQ-026 On press in DEAD the block SHALL go to IDLE, reload row = START_ROW, and clear score.
REQ-027 bird_leds SHALL equal 1 << row, registered; flap and fall SHALL never be high together.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, row START_ROW, counter 0, score 0, flap 0, fall 0, and game_over 0.
REQ-029 Reset SHALL force key_q to 1, so a key held through reset does not count as a press.
REQ-030 Reset asserted mid-game SHALL abort immediately; the first press after release starts a new game.

Structure
REQ-031 Package bird_pkg SHALL hold the state enum, SCORE_MAX = 99, and the default N_ROWS and START_ROW.
REQ-032 Press detection SHALL be the sub-module key_edge (clk, reset, key -> press).

Verification (FALL_PERIOD=4, N_ROWS=8, START_ROW=4)
REQ-033 The bench SHALL check: reset -> bird_leds=00010000, score=0, game_over=0; key held high through reset release -> no press.
REQ-034 The bench SHALL check: press in IDLE, then idle -> flap once, bird_leds=00100000, then fall every 4 cycles: 00010000, 00001000, and so on.
REQ-035 The bench SHALL check: no presses -> fall at row 0 -> game_over=1 and bird_leds=00000001 frozen.
REQ-036 The bench SHALL check: presses landing on the cycle the counter reaches 3 -> flap only, no fall; 5 presses from row 4 -> bird_leds=10000000 held.
REQ-037 The bench SHALL check: pipe_col=00010000 with bird at row 4 in PLAY -> DEAD next cycle, no flap or fall.
REQ-038 The bench SHALL check: 101 pipe_pass pulses -> score=99; press in DEAD -> IDLE, score=0, bird_leds=00010000.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird column controller.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int SCORE_MAX     = 99;
  localparam int SCORE_W       = 7;
  localparam int DEF_N_ROWS    = 8;
  localparam int DEF_START_ROW = 4;

  // Score counts up by one and sticks at SCORE_MAX.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for the player button; held key never repeats.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic key_q;

  // Reset value of 1 masks a key that is already down when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= 1'b1;
    else       key_q <= key;
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/bird_ctrl.sv
// Bird column controller: flap/gravity movement, collision, scoring, game FSM.
module bird_ctrl
  import bird_pkg::*;
#(
  parameter int FALL_PERIOD = 16,
  parameter int N_ROWS      = DEF_N_ROWS,
  parameter int START_ROW   = DEF_START_ROW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic [N_ROWS-1:0]  pipe_col,
  input  logic               pipe_pass,
  output logic [N_ROWS-1:0]  bird_leds,
  output logic               flap,
  output logic               fall,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W = $clog2(FALL_PERIOD);
  localparam logic [ROW_W-1:0] TOP_ROW  = ROW_W'(N_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_INIT = ROW_W'(START_ROW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_PERIOD - 1);

  logic press;
  state_t state_reg, state_next;
  logic [ROW_W-1:0]   row_reg, row_next, row_up;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic flap_reg, flap_next, fall_reg, fall_next;
  logic [N_ROWS-1:0]  leds_reg, leds_next;

  key_edge u_key_edge (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .press (press)
  );

  assign row_up = (row_reg == TOP_ROW) ? row_reg : row_reg + ROW_W'(1);

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    cnt_next   = '0;
    score_next = score_reg;
    flap_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        row_next = ROW_INIT;
        if (press) begin
          state_next = PLAY;
          row_next   = row_up;
          flap_next  = 1'b1;
        end
      end
      PLAY: begin
        if (pipe_pass) score_next = score_inc(score_reg);
        // Collision outranks both press and gravity and freezes the row.
        if (|(leds_reg & pipe_col)) begin
          state_next = DEAD;
        end else if (press) begin
          row_next  = row_up;
          flap_next = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          fall_next = 1'b1;
          if (row_reg == '0) state_next = DEAD;
          else               row_next   = row_reg - ROW_W'(1);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DEAD: begin
        if (press) begin
          state_next = IDLE;
          row_next   = ROW_INIT;
          score_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row_dec
    assign leds_next[gi] = (row_next == ROW_W'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      row_reg   <= ROW_INIT;
      cnt_reg   <= '0;
      score_reg <= '0;
      flap_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      leds_reg  <= N_ROWS'(1) << START_ROW;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      cnt_reg   <= cnt_next;
      score_reg <= score_next;
      flap_reg  <= flap_next;
      fall_reg  <= fall_next;
      leds_reg  <= leds_next;
    end
  end

  assign bird_leds = leds_reg;
  assign flap      = flap_reg;
  assign fall      = fall_reg;
  assign game_over = (state_reg == DEAD);
  assign score     = score_reg;

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl with FALL_PERIOD=4, N_ROWS=8, START_ROW=4.
module tb_bird_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [7:0] pipe_col;
  logic       pipe_pass;
  logic [7:0] bird_leds;
  logic       flap;
  logic       fall;
  logic       game_over;
  logic [6:0] score;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       k;
    logic [7:0] pc;
    logic       pp;
    logic [7:0] leds;
    logic       fl;
    logic       fa;
    logic       go;
    logic [6:0] sc;
  } vec_t;

  vec_t tbl[$];

  bird_ctrl #(.FALL_PERIOD(4), .N_ROWS(8), .START_ROW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .pipe_col  (pipe_col),
    .pipe_pass (pipe_pass),
    .bird_leds (bird_leds),
    .flap      (flap),
    .fall      (fall),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", nm, got, exp);
    else passed++;
  endtask

  function automatic void add(input logic k, input logic [7:0] pc, input logic pp,
                              input logic [7:0] leds, input logic fl, input logic fa,
                              input logic go, input logic [6:0] sc);
    vec_t v;
    v.k = k; v.pc = pc; v.pp = pp; v.leds = leds;
    v.fl = fl; v.fa = fa; v.go = go; v.sc = sc;
    tbl.push_back(v);
  endfunction

  task automatic apply(input string tag, input vec_t v);
    key = v.k; pipe_col = v.pc; pipe_pass = v.pp;
    step();
    $display("%s key=%0b pc=%b pp=%0b -> leds=%b flap=%0b fall=%0b go=%0b score=%0d",
             tag, v.k, v.pc, v.pp, bird_leds, flap, fall, game_over, score);
    chk({tag, ".leds"},  32'(bird_leds), 32'(v.leds));
    chk({tag, ".flap"},  32'(flap),      32'(v.fl));
    chk({tag, ".fall"},  32'(fall),      32'(v.fa));
    chk({tag, ".go"},    32'(game_over), 32'(v.go));
    chk({tag, ".score"}, 32'(score),     32'(v.sc));
    chk({tag, ".excl"},  32'(flap & fall), 32'(0));
  endtask

  function automatic vec_t mk(input logic k, input logic [7:0] pc, input logic pp,
                              input logic [7:0] leds, input logic fl, input logic fa,
                              input logic go, input logic [6:0] sc);
    vec_t v;
    v.k = k; v.pc = pc; v.pp = pp; v.leds = leds;
    v.fl = fl; v.fa = fa; v.go = go; v.sc = sc;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; key = 1'b0; pipe_col = '0; pipe_pass = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] up_rows [4];
    up_rows[0] = 8'h40; up_rows[1] = 8'h80; up_rows[2] = 8'h80; up_rows[3] = 8'h80;

    // Reset with key held high, then release with key still high.
    reset = 1'b1; key = 1'b1; pipe_col = '0; pipe_pass = 1'b0;
    step();
    chk("rst.leds",  32'(bird_leds), 32'h10);
    chk("rst.score", 32'(score),     32'd0);
    chk("rst.go",    32'(game_over), 32'd0);
    chk("rst.flap",  32'(flap),      32'd0);
    reset = 1'b0;
    apply("held_key", mk(1, 8'h00, 0, 8'h10, 0, 0, 0, 0));

    // Main table: start, gravity down to the ground, death, restart.
    add(0, 8'h00, 0, 8'h10, 0, 0, 0, 0);
    add(1, 8'h00, 0, 8'h20, 1, 0, 0, 0);
    for (int r = 4; r >= 0; r--) begin
      for (int q = 0; q < 3; q++) add(0, 8'h00, 0, 8'((1 << (r + 1))), 0, 0, 0, 0);
      add(0, 8'h00, 0, 8'((1 << r)), 0, 1, 0, 0);
    end
    for (int q = 0; q < 3; q++) add(0, 8'h00, 0, 8'h01, 0, 0, 0, 0);
    add(0, 8'h00, 0, 8'h01, 0, 1, 1, 0);
    add(0, 8'h00, 1, 8'h01, 0, 0, 1, 0);
    add(0, 8'h00, 0, 8'h01, 0, 0, 1, 0);
    add(1, 8'h00, 0, 8'h10, 0, 0, 0, 0);
    add(0, 8'h00, 1, 8'h10, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Presses landing exactly on the gravity step, climbing to the top row.
    apply("climb0", mk(1, 8'h00, 0, 8'h20, 1, 0, 0, 0));
    for (int p = 0; p < 4; p++) begin
      logic [7:0] prev;
      prev = (p == 0) ? 8'h20 : up_rows[p - 1];
      for (int q = 0; q < 3; q++) apply($sformatf("climb%0d_w%0d", p, q), mk(0, 8'h00, 0, prev, 0, 0, 0, 0));
      apply($sformatf("climb%0d_p", p + 1), mk(1, 8'h00, 0, up_rows[p], 1, 0, 0, 0));
    end
    for (int q = 0; q < 3; q++) apply($sformatf("top_hold%0d", q), mk(0, 8'h00, 0, 8'h80, 0, 0, 0, 0));
    apply("top_fall", mk(0, 8'h00, 0, 8'h40, 0, 1, 0, 0));

    // Collision at row 4 outranks a coincident press.
    do_reset();
    apply("col_start", mk(1, 8'h00, 0, 8'h20, 1, 0, 0, 0));
    for (int q = 0; q < 3; q++) apply($sformatf("col_w%0d", q), mk(0, 8'h00, 0, 8'h20, 0, 0, 0, 0));
    apply("col_fall", mk(0, 8'h00, 0, 8'h10, 0, 1, 0, 0));
    apply("col_hit",  mk(1, 8'h10, 0, 8'h10, 0, 0, 1, 0));
    apply("col_dead", mk(0, 8'h00, 0, 8'h10, 0, 0, 1, 0));

    // Score saturation across 101 pipe passes, then restart from DEAD.
    do_reset();
    apply("sc_start", mk(1, 8'h00, 0, 8'h20, 1, 0, 0, 0));
    key = 1'b0; step();
    for (int i = 1; i <= 101; i++) begin
      key = 1'b1; pipe_pass = 1'b1;
      step();
      if (i == 1 || i == 50 || i == 99 || i == 100 || i == 101) begin
        $display("pass%0d score=%0d leds=%b", i, score, bird_leds);
        chk($sformatf("score_after%0d", i), 32'(score), (i < 99) ? i : 99);
      end
      key = 1'b0; pipe_pass = 1'b0;
      step();
    end
    apply("sc_hit",    mk(0, 8'h80, 0, 8'h80, 0, 0, 1, 99));
    apply("sc_frozen", mk(0, 8'h00, 1, 8'h80, 0, 0, 1, 99));
    apply("sc_restart", mk(1, 8'h00, 0, 8'h10, 0, 0, 0, 0));

    // Asynchronous reset mid-game, then a fresh game on the next press.
    key = 1'b0; pipe_pass = 1'b0; pipe_col = '0;
    step();
    apply("ar_start", mk(1, 8'h00, 1, 8'h20, 1, 0, 0, 0));
    apply("ar_run",   mk(0, 8'h00, 1, 8'h20, 0, 0, 0, 1));
    #2 reset = 1'b1;
    #1;
    $display("async_reset leds=%b score=%0d go=%0b flap=%0b", bird_leds, score, game_over, flap);
    chk("ar.leds",  32'(bird_leds), 32'h10);
    chk("ar.score", 32'(score),     32'd0);
    chk("ar.flap",  32'(flap),      32'd0);
    step();
    reset = 1'b0;
    apply("ar_idle",  mk(0, 8'h00, 0, 8'h10, 0, 0, 0, 0));
    apply("ar_press", mk(1, 8'h00, 0, 8'h20, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
